// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronises rx, finds the start bit, samples each bit
// at its centre and reports the word with parity and framing status.
module uart_rx_os #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state,    w_state;
    logic [TW-1:0]          r_tick,     w_tick;
    logic [BW-1:0]          r_bit,      w_bit;
    logic [DATA_BITS-1:0]   r_shreg,    w_shreg;
    logic                   r_perr_int, w_perr_int;
    logic                   r_ferr_int, w_ferr_int;
    logic [DATA_BITS-1:0]   r_dout,     w_dout;
    logic                   r_perr,     w_perr;
    logic                   r_ferr,     w_ferr;
    logic                   r_done,     w_done;

    logic                   w_rx_s;
    logic [TW-1:0]          w_tick_inc;
    logic                   w_par;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_tick_inc = r_tick + TW'(1);
    assign w_par      = (^r_shreg) ^ w_rx_s;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and process order does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= '1;
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shreg    <= '0;
            r_perr_int <= 1'b0;
            r_ferr_int <= 1'b0;
            r_dout     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
            r_state    <= w_state;
            r_tick     <= w_tick;
            r_bit      <= w_bit;
            r_shreg    <= w_shreg;
            r_perr_int <= w_perr_int;
            r_ferr_int <= w_ferr_int;
            r_dout     <= w_dout;
            r_perr     <= w_perr;
            r_ferr     <= w_ferr;
            r_done     <= w_done;
        end
    end

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_state    = r_state;
        w_tick     = r_tick;
        w_bit      = r_bit;
        w_shreg    = r_shreg;
        w_perr_int = r_perr_int;
        w_ferr_int = r_ferr_int;
        w_dout     = r_dout;
        w_perr     = r_perr;
        w_ferr     = r_ferr;
        w_done     = 1'b0;

        if (s_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state = S_START;
                        w_tick  = '0;
                    end
                end
                S_START: begin
                    // Re-check the line at start-bit centre to reject glitches.
                    if (w_tick_inc == TW'(OVERSAMPLE/2 - 1)) begin
                        w_tick = '0;
                        if (!w_rx_s) begin
                            w_state    = S_DATA;
                            w_bit      = '0;
                            w_perr_int = 1'b0;
                            w_ferr_int = 1'b0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_tick = w_tick_inc;
                    end
                end
                S_DATA: begin
                    if (r_tick == TW'(OVERSAMPLE - 1)) begin
                        w_tick  = '0;
                        w_shreg = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (r_bit == BW'(DATA_BITS - 1)) begin
                            w_bit   = '0;
                            w_state = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bit = r_bit + BW'(1);
                        end
                    end else begin
                        w_tick = w_tick_inc;
                    end
                end
                S_PARITY: begin
                    if (r_tick == TW'(OVERSAMPLE - 1)) begin
                        w_tick     = '0;
                        w_perr_int = (PARITY == 1) ? ~w_par : w_par;
                        w_state    = S_STOP;
                    end else begin
                        w_tick = w_tick_inc;
                    end
                end
                S_STOP: begin
                    if (r_tick == TW'(OVERSAMPLE - 1)) begin
                        w_tick = '0;
                        if (!w_rx_s) begin
                            w_ferr_int = 1'b1;
                        end
                        if (r_bit == BW'(STOP_BITS - 1)) begin
                            // Leave at stop-bit centre so a back-to-back start edge is seen.
                            w_bit   = '0;
                            w_dout  = r_shreg;
                            w_perr  = r_perr_int;
                            w_ferr  = r_ferr_int | ~w_rx_s;
                            w_done  = 1'b1;
                            w_state = S_IDLE;
                        end else begin
                            w_bit = r_bit + BW'(1);
                        end
                    end else begin
                        w_tick = w_tick_inc;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign rx_done    = r_done;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (8N1, 8E1, 7O2) share clock, reset
// and a 1-in-4 s_tick; each frame is checked against hand-computed values.
module tb_uart_rx_os;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        int         tick;
        int         cyc;
        int         tcyc;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       rx0, rx1, rx2;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic       done0, done1, done2;
    logic       perr0, perr1, perr2;
    logic       ferr0, ferr1, ferr2;
    logic       busy0, busy1, busy2;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_ticks  = 0;
    int   tick_cyc = -1;
    int   frame_start = 0;
    bit   busy_seen0 = 1'b0;
    rec_t q0[$];
    rec_t q1[$];
    rec_t q2[$];
    rec_t r;
    int   div = 0;

    uart_rx_os u_dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx0), .dout(dout0),
        .rx_done(done0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
    );

    uart_rx_os #(.DATA_BITS(8), .PARITY(2)) u_dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx1), .dout(dout1),
        .rx_done(done1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
    );

    uart_rx_os #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx2), .dout(dout2),
        .rx_done(done2), .parity_err(perr2), .frame_err(ferr2), .busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = (div == 3);
            div    = (div + 1) % 4;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (s_tick) begin
            n_ticks  = n_ticks + 1;
            tick_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (done0) q0.push_back('{{1'b0, dout0}, perr0, ferr0, n_ticks, cyc, tick_cyc});
        if (done1) q1.push_back('{{1'b0, dout1}, perr1, ferr1, n_ticks, cyc, tick_cyc});
        if (done2) q2.push_back('{{2'b0, dout2}, perr2, ferr2, n_ticks, cyc, tick_cyc});
        if (busy0) busy_seen0 = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = n_ticks + n;
        while (n_ticks < target) @(negedge clk);
    endtask

    task automatic drive(input int inst, input logic v);
        case (inst)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Line changes land on the negedge right after a tick, so the detecting
    // tick is always the first tick after the falling edge.
    task automatic align();
        @(negedge clk);
        if (cyc != tick_cyc) wait_ticks(1);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit, input int nstop,
                              input bit stop_low);
        align();
        frame_start = n_ticks;
        drive(inst, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            drive(inst, data[i]);
            wait_ticks(16);
        end
        if (has_par) begin
            drive(inst, par_bit);
            wait_ticks(16);
        end
        for (int s = 0; s < nstop; s++) begin
            if (stop_low) begin
                // Low through the centre sample only, so the idle line after it is high.
                drive(inst, 1'b0);
                wait_ticks(8);
                drive(inst, 1'b1);
                wait_ticks(8);
            end else begin
                drive(inst, 1'b1);
                wait_ticks(16);
            end
        end
        drive(inst, 1'b1);
    endtask

    task automatic take(input int inst, output rec_t rr);
        rr = '{9'h0, 1'b0, 1'b0, 0, 0, 0};
        case (inst)
            0: if (q0.size() > 0) rr = q0.pop_front();
            1: if (q1.size() > 0) rr = q1.pop_front();
            default: if (q2.size() > 0) rr = q2.pop_front();
        endcase
    endtask

    task automatic check_rec(input string tag, input rec_t rr, input logic [8:0] d,
                             input logic pe, input logic fe);
        check({tag, "_dout"}, 32'(rr.d), 32'(d));
        check({tag, "_parity_err"}, 32'(rr.pe), 32'(pe));
        check({tag, "_frame_err"}, 32'(rr.fe), 32'(fe));
    endtask

    initial begin
        reset = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_dout", 32'(dout0), 32'h0);
        check("reset_rx_done", 32'(done0), 32'h0);
        check("reset_parity_err", 32'(perr0), 32'h0);
        check("reset_frame_err", 32'(ferr0), 32'h0);
        check("reset_busy", 32'(busy0), 32'h0);
        reset = 1'b0;
        wait_ticks(20);

        // Clean 8N1 0xA5 with exact latency from the detecting tick.
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0);
        wait_ticks(4);
        check("a5_done_count", 32'(q0.size()), 32'd1);
        take(0, r);
        check_rec("a5", r, 9'h0A5, 1'b0, 1'b0);
        check("a5_latency_ticks", 32'(r.tick - frame_start), 32'd152);
        check("a5_done_after_tick_clk", 32'(r.cyc - r.tcyc), 32'd0);
        check("a5_busy_after", 32'(busy0), 32'h0);

        // Even parity: 0x37 has five ones, parity bit 0 is wrong; 0x36 with 0 is right.
        send_frame(1, 9'h037, 8, 1'b1, 1'b0, 1, 1'b0);
        send_frame(1, 9'h036, 8, 1'b1, 1'b0, 1, 1'b0);
        wait_ticks(4);
        check("even_done_count", 32'(q1.size()), 32'd2);
        take(1, r);
        check_rec("even_37", r, 9'h037, 1'b1, 1'b0);
        take(1, r);
        check_rec("even_36", r, 9'h036, 1'b0, 1'b0);

        // Low stop bit on 0x5A, then a clean 0x3C clears the framing flag.
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_ticks(8);
        check("ferr_done_count", 32'(q0.size()), 32'd1);
        take(0, r);
        check_rec("ferr_5a", r, 9'h05A, 1'b0, 1'b1);
        wait_ticks(24);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
        wait_ticks(4);
        check("clean_done_count", 32'(q0.size()), 32'd1);
        take(0, r);
        check_rec("clean_3c", r, 9'h03C, 1'b0, 1'b0);

        // Five-tick low glitch in IDLE is rejected as a false start.
        align();
        busy_seen0 = 1'b0;
        drive(0, 1'b0);
        wait_ticks(5);
        drive(0, 1'b1);
        wait_ticks(24);
        check("glitch_no_done", 32'(q0.size()), 32'd0);
        check("glitch_busy_pulsed", 32'(busy_seen0), 32'd1);
        check("glitch_busy_idle", 32'(busy0), 32'h0);
        check("glitch_dout_held", 32'(dout0), 32'h3C);

        // Reset in the middle of the data bits, then a clean 0xC3.
        align();
        drive(0, 1'b0);
        wait_ticks(16);
        drive(0, 1'b1);
        wait_ticks(16);
        drive(0, 1'b0);
        wait_ticks(16);
        drive(0, 1'b1);
        wait_ticks(6);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_dout", 32'(dout0), 32'h0);
        check("midreset_rx_done", 32'(done0), 32'h0);
        check("midreset_parity_err", 32'(perr0), 32'h0);
        check("midreset_frame_err", 32'(ferr0), 32'h0);
        check("midreset_busy", 32'(busy0), 32'h0);
        reset = 1'b0;
        wait_ticks(200);
        check("midreset_no_done", 32'(q0.size()), 32'd0);
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b0);
        wait_ticks(4);
        check("c3_done_count", 32'(q0.size()), 32'd1);
        take(0, r);
        check_rec("c3", r, 9'h0C3, 1'b0, 1'b0);

        // 7O2 back-to-back: 0x7F (seven ones, odd parity bit 0), then 0x01 (parity bit 0).
        send_frame(2, 9'h07F, 7, 1'b1, 1'b0, 2, 1'b0);
        send_frame(2, 9'h001, 7, 1'b1, 1'b0, 2, 1'b0);
        wait_ticks(4);
        check("b2b_done_count", 32'(q2.size()), 32'd2);
        take(2, r);
        check_rec("b2b_7f", r, 9'h07F, 1'b0, 1'b0);
        take(2, r);
        check_rec("b2b_01", r, 9'h001, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
